// File: rtl/flit_decompressor_pipe.sv
// Base-delta flit decompressor for the NoC ejection port: latches per-body encoding/base pairs
// from the head flit and subtracts the selected base from every body chunk. Optional FLITZIP_ERR_CNT_EN adds err_cnt_out.
module flit_decompressor_pipe #(
  parameter int unsigned FLIT_WIDTH = 128,
  parameter int unsigned CHUNK_SIZE = 8,
  parameter int unsigned EN_BITS    = 3,
  parameter int unsigned BODY_FLITS = 4,
  parameter int unsigned META_START = 75
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_head,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_is_head,
  output logic                  out_is_tail,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  err_out
`ifdef FLITZIP_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt_out
`endif
);

  localparam int unsigned NCHUNK = FLIT_WIDTH / CHUNK_SIZE;
  localparam int unsigned PAIR_W = EN_BITS + CHUNK_SIZE;
  localparam int unsigned META_W = BODY_FLITS * PAIR_W;
  localparam int unsigned CNT_W  = (BODY_FLITS > 1) ? $clog2(BODY_FLITS) : 1;

  typedef enum logic {IDLE, BODY} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [META_W-1:0]       meta_q, meta_d;
  logic                    valid_d, head_d, tail_d, err_d;
  logic [FLIT_WIDTH-1:0]   data_d;
  logic                    accept_c;
  logic                    err_evt_c;
  logic [PAIR_W-1:0]       pairs_c [BODY_FLITS];
  logic [PAIR_W-1:0]       sel_pair_c;
  logic [CHUNK_SIZE-1:0]   sub_c;
  logic [FLIT_WIDTH-1:0]   body_c;

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Pair 0 sits at the MSB end of the latched metadata.
  always_comb begin
    for (int b = 0; b < BODY_FLITS; b++) begin
      pairs_c[b] = meta_q[META_W-1-b*PAIR_W -: PAIR_W];
    end
  end

  assign sel_pair_c = pairs_c[cnt_q];
  assign sub_c = (sel_pair_c[PAIR_W-1 -: EN_BITS] != '0) ? sel_pair_c[CHUNK_SIZE-1:0] : '0;

  // Chunk-wise modular subtraction; chunk 0 is the MSB chunk.
  always_comb begin
    body_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      body_c[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE] =
        data_in[FLIT_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE] - sub_c;
    end
  end

  // Next-state, packet tracking and output stage loading.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    meta_d    = meta_q;
    valid_d   = out_valid;
    head_d    = out_is_head;
    tail_d    = out_is_tail;
    data_d    = data_out;
    err_evt_c = 1'b0;

    if (accept_c) begin
      valid_d = 1'b1;
      head_d  = in_is_head;
      tail_d  = 1'b0;
      data_d  = data_in;
      if (in_is_head) begin
        // A head in BODY abandons the truncated packet and restarts on the new pairs.
        err_evt_c = (state_q == BODY);
        meta_d    = data_in[META_START -: META_W];
        cnt_d     = '0;
        state_d   = BODY;
      end else if (state_q == IDLE) begin
        err_evt_c = 1'b1;
      end else begin
        data_d = body_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BODY_FLITS - 1)) begin
          tail_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    err_d = err_out || err_evt_c;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      meta_q      <= '0;
      out_valid   <= 1'b0;
      out_is_head <= 1'b0;
      out_is_tail <= 1'b0;
      data_out    <= '0;
      err_out     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      meta_q      <= meta_d;
      out_valid   <= valid_d;
      out_is_head <= head_d;
      out_is_tail <= tail_d;
      data_out    <= data_d;
      err_out     <= err_d;
    end
  end

`ifdef FLITZIP_ERR_CNT_EN
  // Saturating count of protocol error events.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_cnt_out <= '0;
    end else if (err_evt_c && (err_cnt_out != 8'hFF)) begin
      err_cnt_out <= err_cnt_out + 8'd1;
    end
  end
`endif

endmodule

// File: doc/flit_decompressor_pipe.md
Name: flit_decompressor_pipe

Overview:
- Parametrised base-delta decompressor for NoC packets; sits at the destination router's ejection port, ahead of the local sink.
- A head flit carries one encoding/base pair per body flit. The block latches these pairs, walks through the body flits with a flit counter, and subtracts the selected base from every chunk.
- Valid/ready handshake on both sides; one registered output stage.

Parameters:
- FLIT_WIDTH, 128, input and output flit width in bits.
- CHUNK_SIZE, 8, chunk and base width; FLIT_WIDTH must be a multiple of it; NCHUNK = FLIT_WIDTH/CHUNK_SIZE.
- EN_BITS, 3, encoding field width per pair.
- BODY_FLITS, 4, body flits per packet; equals the number of pairs in the head.
- META_START, 75, MSB index of the metadata field in the head flit.
- PAIR_W = EN_BITS+CHUNK_SIZE, local parameter, 11 by default; metadata occupies bits META_START down to META_START-BODY_FLITS*PAIR_W+1.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  synchronous reset, active-high.
- in_valid  in  1  input flit valid.
- in_ready  out  1  block accepts the input flit this cycle.
- in_is_head  in  1  input flit is a head flit.
- data_in  in  FLIT_WIDTH  compressed flit.
- out_valid  out  1  output flit valid.
- out_ready  in  1  sink accepts the output flit.
- out_is_head  out  1  output flit is a head.
- out_is_tail  out  1  output flit is the last body flit.
- data_out  out  FLIT_WIDTH  decompressed flit.
- err_out  out  1  sticky protocol-error flag.

Behaviour:
- Reset, taking priority over all else: state=IDLE, flit counter=0, metadata register=0, out_valid=0, out_is_head=0, out_is_tail=0, data_out=0, err_out=0.
- Handshake:
  - in_ready = !out_valid || out_ready. It is combinational and never depends on in_valid.
  - A flit transfers when in_valid && in_ready; every accepted flit produces exactly one output flit.
  - Output registers load on acceptance. The output holds stable while out_valid && !out_ready.
  - Latency is 1 cycle. Full throughput (1 flit/cycle) when out_ready stays high.
- States:
  - IDLE: an accepted head latches the metadata field, counter=0, state goes to BODY. An accepted body sets err_out, is forwarded raw with out_is_head=0 and out_is_tail=0, and the state stays IDLE.
  - BODY: an accepted body uses pair[counter] (pair 0 at the MSB end of the metadata). Counter increments. When counter == BODY_FLITS-1, out_is_tail=1, counter resets to 0 and state goes to IDLE.
  - BODY, head accepted: err_out is set, metadata is re-latched, counter=0, state stays BODY. This abandons the truncated packet.
- Head flit passes through unmodified with out_is_head=1.
- Arithmetic:
  - en = pair[PAIR_W-1 -: EN_BITS], base = pair[CHUNK_SIZE-1:0].
  - en == 0: raw chunks, subtrahend 0. en != 0: subtrahend = base.
  - Each chunk i: out_chunk = in_chunk - subtrahend, modulo 2^CHUNK_SIZE (wrap, no saturation). Example: 0x03 - 0x05 = 0xFE.
  - Chunk 0 is the MSB chunk.
- No input accepted: the counter and state do not change.
- err_out clears only on reset.
- Reset mid-packet discards the packet state. The first flit after reset must be a head, otherwise err_out is set.

Optional Feature:
- Macro: FLITZIP_ERR_CNT_EN.
- Defined: adds output port err_cnt_out[7:0], reset to 0. It increments, saturating at 0xFF, on each protocol error event: a body accepted in IDLE, or a head accepted in BODY. A simultaneous reset wins.
- Not defined: no port and no counter; err_out behaviour is unchanged.

Test Plan:
- Basic packet:
  - Stimulus: head with pairs {en=1,base=0x10},{en=0,base=0x55},{en=7,base=0xFF},{en=2,base=0x01}, then 4 bodies of all-0x20 chunks, out_ready=1.
  - Required: head unchanged; bodies all 0x10, all 0x20, all 0x21, all 0x1F. Tail flag only on the 4th body. Each output 1 cycle after its input.
- Wrap-around: en=1, base=0x05, body chunks 0x03 -> chunks 0xFE. Chunk 0x05 -> 0x00.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles mid-packet.
  - Required: in_ready=0; data_out and out_is_tail stable. No flit lost or duplicated after release.
- Protocol errors:
  - Body in IDLE -> forwarded raw, err_out=1, err_cnt_out=1.
  - Head after 2 bodies -> counter restarts; next 4 bodies use the new pairs 0..3; err_cnt_out=2.
- Reset: assert rst_in after 2 bodies with out_valid=1 -> next cycle out_valid=0, err_out=0. A new head+4 bodies decompress with pair index starting at 0.
- Back-to-back: two packets streamed with no gaps -> second head accepted the cycle after the first tail; 10 outputs in 10 cycles.
